// File: rtl/cdiv_pkg.sv
// Shared constants and types for the sc16 complex divider.
package cdiv_pkg;
  localparam int I_MSB = 31;
  localparam int I_LSB = 16;
  localparam int Q_MSB = 15;
  localparam int Q_LSB = 0;

  localparam int QBITS   = 15;
  localparam int LATENCY = 19;

  localparam int NUM_LANES = 2;
  localparam int LANE_RE   = 0;
  localparam int LANE_IM   = 1;

  localparam int TU_DBZ = 0;
  localparam int TU_SAT = 1;

  typedef enum logic [2:0] {IDLE, MUL, PREP, DIV, ROUND, OUT} state_t;
endpackage

// File: rtl/cdiv_16_if.sv
// Stream handshake bundle for cdiv_16: a/b sample pair in, quotient out.
interface cdiv_16_if;
  logic [31:0] a_tdata;
  logic [31:0] b_tdata;
  logic        i_tvalid;
  logic        i_tlast;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic [1:0]  o_tuser;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;

  modport slave (
    input  a_tdata, b_tdata, i_tvalid, i_tlast, o_tready,
    output i_tready, o_tdata, o_tuser, o_tlast, o_tvalid
  );

  modport master (
    output a_tdata, b_tdata, i_tvalid, i_tlast, o_tready,
    input  i_tready, o_tdata, o_tuser, o_tlast, o_tvalid
  );
endinterface

// File: rtl/cdiv_16_udiv_serial.sv
// Unsigned restoring divider slice: one quotient bit per step, MSB first.
// Caller guarantees dividend[QW+31:QW] < den for a meaningful result.
module udiv_serial #(
  parameter int QW = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic [QW+31:0]  dividend,
  input  logic [31:0]     den,
  output logic [QW-1:0]   q_mag,
  output logic [31:0]     rem
);
  logic [31:0]   rem_q;
  logic [QW-1:0] lo_q, quo_q;
  logic [32:0]   trial;
  logic [31:0]   diff;
  logic          ge;

  always_comb begin
    trial = {rem_q, lo_q[QW-1]};
    ge    = trial >= {1'b0, den};
    // only used when ge, so the low 32 bits are exact
    diff  = trial[31:0] - den;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      lo_q  <= '0;
      quo_q <= '0;
    end else if (load) begin
      rem_q <= dividend[QW+31:QW];
      lo_q  <= dividend[QW-1:0];
      quo_q <= '0;
    end else if (step) begin
      rem_q <= ge ? diff : trial[31:0];
      lo_q  <= lo_q << 1;
      quo_q <= {quo_q[QW-2:0], ge};
    end
  end

  assign q_mag = quo_q;
  assign rem   = rem_q;
endmodule

// File: rtl/cdiv_16.sv
// sc16 complex divide p = a/b computed as a*conj(b)/|b|^2, one sample in flight.
module cdiv_16
  import cdiv_pkg::*;
#(
  parameter int FRAC_BITS = 12
) (
  input  logic      clk,
  input  logic      reset_n,
  cdiv_16_if.slave  s
);
  localparam int DW = 32 + QBITS;

  state_t state, state_nxt;
  logic   load, step;
  logic [3:0] cnt;

  logic [31:0] a_q, b_q;
  logic        last_q;
  logic signed [31:0] ai_x, aq_x, bi_x, bq_x;
  logic signed [31:0] p_ii, p_qq, p_qi, p_iq, p_bi, p_bq;

  logic [NUM_LANES-1:0][32:0]      num;
  logic [NUM_LANES-1:0][31:0]      mag;
  logic [NUM_LANES-1:0][DW-1:0]    dvd;
  logic [NUM_LANES-1:0]            neg_c, sat_c;
  logic [31:0]                     den_c, den_q;
  logic [NUM_LANES-1:0]            neg_q, sat_q;
  logic                            dbz_q;
  logic [NUM_LANES-1:0][QBITS-1:0] q_mag;
  logic [NUM_LANES-1:0][31:0]      rem;
  logic [NUM_LANES-1:0][15:0]      qr, res;
  logic [NUM_LANES-1:0]            clip;
  logic [1:0]                      tuser_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE:  if (s.i_tvalid) state_nxt = MUL;
      MUL:   state_nxt = PREP;
      PREP:  begin load = 1'b1; state_nxt = DIV; end
      DIV:   begin step = 1'b1; if (cnt == 4'd0) state_nxt = ROUND; end
      ROUND: state_nxt = OUT;
      OUT:   if (s.o_tready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign s.i_tready = (state == IDLE);
  assign s.o_tvalid = (state == OUT);

  assign ai_x = 32'($signed(a_q[I_MSB:I_LSB]));
  assign aq_x = 32'($signed(a_q[Q_MSB:Q_LSB]));
  assign bi_x = 32'($signed(b_q[I_MSB:I_LSB]));
  assign bq_x = 32'($signed(b_q[Q_MSB:Q_LSB]));

  // numerator = a*conj(b); magnitudes go to the dividers, signs are kept aside
  always_comb begin
    num[LANE_RE] = {p_ii[31], p_ii} + {p_qq[31], p_qq};
    num[LANE_IM] = {p_qi[31], p_qi} - {p_iq[31], p_iq};
    den_c        = p_bi + p_bq;
    for (int l = 0; l < NUM_LANES; l++) begin
      neg_c[l] = num[l][32];
      mag[l]   = neg_c[l] ? (32'd0 - num[l][31:0]) : num[l][31:0];
      dvd[l]   = {{QBITS{1'b0}}, mag[l]} << FRAC_BITS;
      sat_c[l] = dvd[l] >= {den_c, {QBITS{1'b0}}};
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    udiv_serial #(.QW(QBITS)) u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .step     (step),
      .dividend (dvd[l]),
      .den      (den_q),
      .q_mag    (q_mag[l]),
      .rem      (rem[l])
    );
  end

  // round half away from zero, then sign and clip to sc16
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      qr[l]   = {1'b0, q_mag[l]} + 16'({rem[l], 1'b0} >= {1'b0, den_q});
      clip[l] = sat_q[l];
      if (sat_q[l])      res[l] = neg_q[l] ? 16'h8000 : 16'h7FFF;
      else if (neg_q[l]) res[l] = 16'd0 - qr[l];
      else if (qr[l][15]) begin
        res[l]  = 16'h7FFF;
        clip[l] = 1'b1;
      end else           res[l] = qr[l];
    end
    tuser_c         = '0;
    tuser_c[TU_DBZ] = dbz_q;
    tuser_c[TU_SAT] = !dbz_q && (|clip);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      last_q    <= 1'b0;
      p_ii      <= '0;
      p_qq      <= '0;
      p_qi      <= '0;
      p_iq      <= '0;
      p_bi      <= '0;
      p_bq      <= '0;
      den_q     <= '0;
      neg_q     <= '0;
      sat_q     <= '0;
      dbz_q     <= 1'b0;
      cnt       <= '0;
      s.o_tdata <= '0;
      s.o_tuser <= '0;
      s.o_tlast <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s.i_tvalid) begin
          a_q    <= s.a_tdata;
          b_q    <= s.b_tdata;
          last_q <= s.i_tlast;
        end
        MUL: begin
          p_ii <= ai_x * bi_x;
          p_qq <= aq_x * bq_x;
          p_qi <= aq_x * bi_x;
          p_iq <= ai_x * bq_x;
          p_bi <= bi_x * bi_x;
          p_bq <= bq_x * bq_x;
        end
        PREP: begin
          den_q <= den_c;
          neg_q <= neg_c;
          sat_q <= sat_c;
          dbz_q <= (den_c == 32'd0);
          cnt   <= 4'(QBITS - 1);
        end
        DIV: cnt <= cnt - 4'd1;
        ROUND: begin
          s.o_tdata <= dbz_q ? 32'd0 : {res[LANE_RE], res[LANE_IM]};
          s.o_tuser <= tuser_c;
          s.o_tlast <= last_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cdiv_16.sv
// Directed vector bench for cdiv_16: table of hand-computed quotients plus
// backpressure and mid-operation reset sequences.
module tb_cdiv_16;
  import cdiv_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic [1:0]  exp_user;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cdiv_16_if bus ();
  cdiv_16 #(.FRAC_BITS(12)) dut (.clk(clk), .reset_n(reset_n), .s(bus));

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[15];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one pair, wait for handshake, then count cycles until o_tvalid.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                      output int lat);
    int w;
    bus.a_tdata  = a;
    bus.b_tdata  = b;
    bus.i_tlast  = last;
    bus.i_tvalid = 1'b1;
    w = 0;
    while (!bus.i_tready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 bus.i_tvalid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.o_tvalid && lat < 40);
    if (!bus.o_tvalid) lat = -1;
  endtask

  task automatic run_vec(input int idx, input logic last);
    int lat;
    send(tbl[idx].a, tbl[idx].b, last, lat);
    check($sformatf("latency[%0d]", idx), 40'(lat), 40'(LATENCY));
    check($sformatf("data[%0d]", idx), 40'(bus.o_tdata), 40'(tbl[idx].exp_data));
    check($sformatf("user[%0d]", idx), 40'(bus.o_tuser), 40'(tbl[idx].exp_user));
    check($sformatf("last[%0d]", idx), 40'(bus.o_tlast), 40'(last));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [39:0] snap;
    int lat;
    bit seen;

    tbl[0]  = '{32'h4000_0000, 32'h4000_0000, 32'h1000_0000, 2'b00};
    tbl[1]  = '{32'h2000_2000, 32'h0000_4000, 32'h0800_F800, 2'b00};
    tbl[2]  = '{32'h0000_4000, 32'h4000_0000, 32'h0000_1000, 2'b00};
    tbl[3]  = '{32'h0001_0000, 32'h0003_0000, 32'h0555_0000, 2'b00};
    tbl[4]  = '{32'h0002_0000, 32'h0003_0000, 32'h0AAB_0000, 2'b00};
    tbl[5]  = '{32'hFFFE_0000, 32'h0003_0000, 32'hF555_0000, 2'b00};
    tbl[6]  = '{32'h7FFF_0000, 32'h0001_0000, 32'h7FFF_0000, 2'b10};
    tbl[7]  = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 2'b10};
    tbl[8]  = '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 2'b01};
    tbl[9]  = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 2'b00};
    tbl[10] = '{32'h0000_7FFF, 32'h0001_0000, 32'h0000_7FFF, 2'b10};
    // dividend exactly den<<15 saturates; one below does not
    tbl[11] = '{32'h0008_0000, 32'h0001_0000, 32'h7FFF_0000, 2'b10};
    tbl[12] = '{32'h0007_0000, 32'h0001_0000, 32'h7000_0000, 2'b00};
    // q=32767 rounds up to 32768: positive clips and flags, negative fits
    tbl[13] = '{32'h0007_7FF8, 32'h0001_0FFF, 32'h7FFF_0001, 2'b10};
    tbl[14] = '{32'hFFF9_8008, 32'h0001_0FFF, 32'h8000_FFFF, 2'b00};

    bus.a_tdata  = '0;
    bus.b_tdata  = '0;
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
    bus.o_tready = 1'b1;

    #1;
    check("reset_state", {3'b0, bus.o_tvalid, bus.i_tready, bus.o_tlast, bus.o_tuser, bus.o_tdata},
          {3'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0});
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(i, logic'(i % 2));

    // Backpressure: outputs frozen and input blocked while o_tready is low
    bus.o_tready = 1'b0;
    send(32'h2000_2000, 32'h0000_4000, 1'b1, lat);
    check("bp_latency", 40'(lat), 40'(LATENCY));
    snap = {3'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0800_F800};
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold[%0d]", c),
            {3'b0, bus.o_tvalid, bus.i_tready, bus.o_tlast, bus.o_tuser, bus.o_tdata}, snap);
      @(negedge clk);
    end
    bus.o_tready = 1'b1;
    @(negedge clk);
    check("bp_release", 40'({bus.o_tvalid, bus.i_tready}), 40'(2'b01));

    // Mid-operation reset at T+8 discards the in-flight sample
    bus.a_tdata  = 32'h4000_0000;
    bus.b_tdata  = 32'h4000_0000;
    bus.i_tlast  = 1'b0;
    bus.i_tvalid = 1'b1;
    @(posedge clk);
    #1 bus.i_tvalid = 1'b0;
    for (int c = 0; c < 8; c++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid", {3'b0, bus.o_tvalid, bus.i_tready, bus.o_tlast, bus.o_tuser, bus.o_tdata},
          {3'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0});
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.o_tvalid) seen = 1'b1;
    end
    check("rst_no_output", 40'(seen), 40'(0));
    run_vec(3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
